// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache miss/refill sequencer: stalls fetch on a miss, reads the line, writes it into the cache.
// Define ICACHE_PREFETCH_EN to add a next-line prefetch after every demand refill.
module icache_refill_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             fetchValid,
    input  logic [31:0]      fetchAddr,
    input  logic             hit,
    input  logic             redirect,
    output logic             memReq,
    output logic [31:0]      memAddr,
    input  logic             memReady,
    input  logic [127:0]     memData,
    output logic             fillEn,
    output logic [31:0]      fillAddr,
    output logic [127:0]     fillData,
    output logic             stall,
    output logic             busErr,
    output logic [CNT_W-1:0] missCount
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        FILL    = 3'd2,
        REPLAY  = 3'd3
`ifdef ICACHE_PREFETCH_EN
        ,
        PF_REQ  = 3'd4,
        PF_FILL = 3'd5
`endif
    } stateT;

    stateT             stateReg, stateNext;
    logic [31:0]       lineAddrReg, lineAddrNext;
    logic [TO_W-1:0]   timeoutReg, timeoutNext;
    logic [31:0]       fillAddrReg;
    logic [127:0]      lineBufReg;
    logic              busErrReg;
    logic [CNT_W-1:0]  missCountReg;
    logic              redirBitReg;
    logic              miss;
    logic [31:0]       missLine;
    logic              captureLine;
    logic              setBusErr;
    logic              incMiss;
`ifdef ICACHE_PREFETCH_EN
    logic              pendReg;
    logic [31:0]       pendAddrReg;
`endif

    assign miss      = fetchValid && !hit;
    assign missLine  = fetchAddr & 32'hFFFF_FFF0;
    assign memAddr   = lineAddrReg;
    assign fillAddr  = fillAddrReg;
    assign fillData  = lineBufReg;
    assign busErr    = busErrReg;
    assign missCount = missCountReg;

    always_comb begin
        stateNext    = stateReg;
        lineAddrNext = lineAddrReg;
        timeoutNext  = timeoutReg;
        memReq       = 1'b0;
        stall        = 1'b0;
        fillEn       = 1'b0;
        captureLine  = 1'b0;
        setBusErr    = 1'b0;
        incMiss      = 1'b0;
        case (stateReg)
            IDLE: begin
                stall = miss;
                if (miss) begin
                    stateNext    = REQ;
                    lineAddrNext = missLine;
                    timeoutNext  = '0;
                end
            end
            REQ: begin
                memReq = 1'b1;
                stall  = 1'b1;
                // memReady on the final allowed cycle still wins over the timeout
                if (memReady) begin
                    captureLine = 1'b1;
                    stateNext   = FILL;
                end else if (timeoutReg == TO_LAST) begin
                    setBusErr = 1'b1;
                    stateNext = IDLE;
                end else begin
                    timeoutNext = timeoutReg + TO_W'(1);
                end
            end
            FILL: begin
                fillEn    = 1'b1;
                stall     = 1'b1;
                incMiss   = 1'b1;
                stateNext = (redirBitReg || redirect) ? IDLE : REPLAY;
            end
            REPLAY: begin
                stall = 1'b1;
`ifdef ICACHE_PREFETCH_EN
                stateNext    = PF_REQ;
                lineAddrNext = lineAddrReg + 32'd16;
                timeoutNext  = '0;
`else
                stateNext = IDLE;
`endif
            end
`ifdef ICACHE_PREFETCH_EN
            PF_REQ: begin
                memReq = 1'b1;
                stall  = pendReg || miss;
                if (memReady) begin
                    captureLine = 1'b1;
                    stateNext   = PF_FILL;
                end else if (timeoutReg == TO_LAST) begin
                    setBusErr = 1'b1;
                    stateNext = IDLE;
                end else begin
                    timeoutNext = timeoutReg + TO_W'(1);
                end
            end
            PF_FILL: begin
                fillEn = 1'b1;
                stall  = pendReg || miss;
                if (pendReg) begin
                    stateNext    = REQ;
                    lineAddrNext = pendAddrReg;
                    timeoutNext  = '0;
                end else begin
                    stateNext = IDLE;
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateReg     <= IDLE;
            lineAddrReg  <= '0;
            timeoutReg   <= '0;
            fillAddrReg  <= '0;
            lineBufReg   <= '0;
            busErrReg    <= 1'b0;
            missCountReg <= '0;
            redirBitReg  <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            lineAddrReg <= lineAddrNext;
            timeoutReg  <= timeoutNext;
            if (captureLine) begin
                lineBufReg  <= memData;
                fillAddrReg <= lineAddrReg;
            end
            if (setBusErr)
                busErrReg <= 1'b1;
            if (incMiss && (missCountReg != '1))
                missCountReg <= missCountReg + CNT_W'(1);
            // A redirect only changes whether REPLAY is needed; the refill itself always completes
            if (stateNext == IDLE)
                redirBitReg <= 1'b0;
            else if ((stateReg == REQ || stateReg == FILL) && redirect)
                redirBitReg <= 1'b1;
        end
    end

`ifdef ICACHE_PREFETCH_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pendReg     <= 1'b0;
            pendAddrReg <= '0;
        end else if (stateReg == PF_FILL || stateNext == IDLE) begin
            pendReg <= 1'b0;
        end else if (stateReg == PF_REQ && miss && !pendReg) begin
            pendReg     <= 1'b1;
            pendAddrReg <= missLine;
        end
    end
`endif

endmodule

// File: doc/icache_refill_ctrl.md
# icache_refill_ctrl

Miss/refill sequencer for the level-1 instruction cache in the fetch stage. The controller watches the cache hit flag for the current PC and stalls fetch on a miss. It fetches the 128-bit line from instruction memory through a request/ready handshake, writes the line into the cache, and then releases the PC. It sits between the PC register, the instruction cache and the instruction memory.

## Interface
- TIMEOUT, 64: maximum cycles in REQ waiting for memReady before the request is abandoned.
- CNT_W, 16: width of the miss counter.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- fetchValid  in  1  fetchAddr carries a real fetch this cycle.
- fetchAddr  in  32  current PC (byte address).
- hit  in  1  cache hit for fetchAddr, combinational from the cache.
- redirect  in  1  branch taken (PCSrc) this cycle.
- memReq  out  1  line read request to instruction memory.
- memAddr  out  32  line-aligned request address, {addr[31:4],4'b0}.
- memReady  in  1  memData valid; completes the request.
- memData  in  128  returned line.
- fillEn  out  1  one-cycle cache write strobe.
- fillAddr  out  32  line address being written.
- fillData  out  128  line being written.
- stall  out  1  hold PC and suppress decode.
- busErr  out  1  sticky flag set when a request times out.
- missCount  out  CNT_W  number of completed demand refills; saturates.

## Operation
- States: IDLE, REQ, FILL, REPLAY, plus PF_REQ and PF_FILL when ICACHE_PREFETCH_EN is defined.
- **IDLE**
  - A miss is fetchValid && !hit.
  - stall equals the miss condition combinationally.
  - On a miss: latch lineAddr = {fetchAddr[31:4],4'b0}, clear the timeout counter, go to REQ.
- **REQ**
  - memReq=1, memAddr=lineAddr, stall=1.
  - If memReady is sampled high: register memData into lineBuf, go to FILL.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: set busErr, drop memReq, go to IDLE with no fill and no missCount increment.
- **FILL**
  - fillEn=1 for exactly one cycle; fillAddr=lineAddr, fillData=lineBuf; stall=1.
  - missCount += 1, saturating at all-ones.
  - Go to REPLAY, or to IDLE if a redirect was recorded.
- **REPLAY**
  - stall=1 for one cycle so the cache re-reads the now-valid line.
  - Go to IDLE.
- **Redirect**
  - A redirect during REQ or FILL does not cancel the outstanding request.
  - The line is still written into the cache; a recorded-redirect bit makes FILL skip REPLAY.
  - The bit clears on entry to IDLE.
  - A redirect in IDLE is ignored; the PC mux handles it.
- Outside FILL: fillEn=0, and fillAddr/fillData hold their last values.
- memReq is held high until memReady. The request address must not change while memReq=1.
- memReady while memReq=0 is ignored.

## Timing
- **Reset**
  - state=IDLE; memReq=0, memAddr=0, fillEn=0, fillAddr=0, fillData=0.
  - busErr=0, missCount=0, redirect bit=0.
  - stall=0 unless an IDLE miss is present, since stall is combinational in IDLE.
- Reset mid-refill aborts at the next edge with no fill strobe. A memReady arriving afterwards is ignored.
- **Latency**
  - Miss seen at edge 0 → REQ from cycle 1.
  - memReady at cycle k → FILL at k+1, REPLAY at k+2, IDLE at k+3 with hit=1.
  - Minimum miss penalty, with memReady in cycle 1, is 4 stall cycles.
- memReady and a redirect in the same cycle: the fill proceeds and REPLAY is skipped.
- Timeout boundary: memReady in the same cycle the counter reaches TIMEOUT counts as success, and busErr stays 0.
- A hit in IDLE produces no stall and no memory traffic.

## Configuration
- **ICACHE_PREFETCH_EN defined:** after a demand FILL, the controller issues a next-line prefetch.
  - Sequence: REPLAY → PF_REQ(lineAddr+16) → PF_FILL → IDLE.
  - stall=0 during PF_REQ/PF_FILL.
  - A demand miss seen during PF_REQ waits until the prefetch completes, then enters REQ; stall=1 while it waits.
  - The prefetch address wraps modulo 2^32.
  - Prefetches do not increment missCount. A prefetch timeout sets busErr.
- **ICACHE_PREFETCH_EN not defined:** the PF states do not exist, and REPLAY always returns to IDLE.

## Test plan
- **Reset then hit:** Reset=1 for 2 cycles, then fetchValid=1, hit=1, PC=0x00 → stall=0, memReq=0, missCount=0.
- **Single miss:** miss at PC=0x1C, memReady=1 on the 3rd REQ cycle with memData=0x0123…CDEF →
  - memAddr=0x10;
  - fillEn for one cycle with fillAddr=0x10 and fillData=0x0123…CDEF;
  - stall high for 6 cycles;
  - missCount=1.
- **Redirect during REQ:** miss at 0x40, redirect=1 while waiting → fill of line 0x40 still occurs, no REPLAY cycle, IDLE one cycle earlier.
- **Timeout:** TIMEOUT=8, memReady never asserted → memReq drops after 8 REQ cycles, busErr=1 and stays set, missCount unchanged, fillEn never pulses.
- **Reset mid-REQ:** Reset asserted on the 2nd REQ cycle, memReady=1 the cycle after → state=IDLE, no fillEn, missCount=0.
- **Prefetch (ICACHE_PREFETCH_EN):** miss at 0xFFFFFFF0 → after the demand fill, PF_REQ with memAddr=0x00000000, stall=0 during the prefetch, missCount=1.
